// File: rtl/counter_pkg.sv
// Shared definitions for the run-counter scheduler: FSM state codes and default run-length width.
package counter_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam int CNT_W_DEFAULT = 7;

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin picker: first asserted request at or above ptr, wrapping to the lowest.
module rr_picker #(
  parameter  int N     = 4,
  localparam int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic             valid,
  output logic [IDX_W-1:0] idx
);

  logic             hit_hi;
  logic [IDX_W-1:0] idx_hi;
  logic [IDX_W-1:0] idx_lo;

  // Scan downward so the lowest qualifying index wins in each half of the ring.
  always_comb begin
    hit_hi = 1'b0;
    idx_hi = {IDX_W{1'b0}};
    idx_lo = {IDX_W{1'b0}};
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) begin
        idx_lo = IDX_W'(i);
        if (IDX_W'(i) >= ptr) begin
          hit_hi = 1'b1;
          idx_hi = IDX_W'(i);
        end else begin
          hit_hi = hit_hi;
        end
      end else begin
        idx_lo = idx_lo;
      end
    end
    valid = |req;
    if (hit_hi) begin
      idx = idx_hi;
    end else begin
      idx = idx_lo;
    end
  end

endmodule

// File: rtl/counter_scheduler.sv
// Shares one run-counter engine among N requesters: round-robin grant, count the
// requested run length, pulse completion to the owner, then re-arbitrate.
module counter_scheduler
  import counter_pkg::*;
#(
  parameter  int N     = 4,
  parameter  int CNT_W = CNT_W_DEFAULT,
  localparam int IDX_W = $clog2(N)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [N-1:0]       i_req,
  input  logic [N*CNT_W-1:0] i_num_cnt,
  output logic [N-1:0]       o_grant,
  output logic [N-1:0]       o_done,
  output logic               o_idle,
  output logic               o_run,
  output logic [IDX_W-1:0]   o_cur_id
);

  state_t           state_q,  state_d;
  logic [CNT_W-1:0] cnt_q,    cnt_d;
  logic [CNT_W-1:0] len_q,    len_d;
  logic [IDX_W-1:0] ptr_q,    ptr_d;
  logic [IDX_W-1:0] cur_id_q, cur_id_d;

  logic             pick_valid_s;
  logic [IDX_W-1:0] pick_idx_s;
  logic [CNT_W-1:0] len_sel_s;
  logic [CNT_W-1:0] len_last_s;
  logic [N-1:0]     owner_oh_s;

  rr_picker #(.N(N)) u_picker (
    .req   (i_req),
    .ptr   (ptr_q),
    .valid (pick_valid_s),
    .idx   (pick_idx_s)
  );

  // Winner's run-length slice and the one-hot form of the current owner.
  always_comb begin
    len_sel_s  = {CNT_W{1'b0}};
    owner_oh_s = {N{1'b0}};
    for (int i = 0; i < N; i++) begin
      if (pick_idx_s == IDX_W'(i)) begin
        len_sel_s = i_num_cnt[i*CNT_W +: CNT_W];
      end else begin
        len_sel_s = len_sel_s;
      end
      owner_oh_s[i] = (cur_id_q == IDX_W'(i));
    end
    // len 0 wraps to all-ones, giving a full 2^CNT_W-cycle run.
    len_last_s = len_q - CNT_W'(1);
  end

  // Next-state logic for the IDLE/RUN/DONE sequencer and its datapath registers.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    len_d    = len_q;
    ptr_d    = ptr_q;
    cur_id_d = cur_id_q;
    case (state_q)
      S_IDLE: begin
        if (pick_valid_s) begin
          state_d  = S_RUN;
          cur_id_d = pick_idx_s;
          len_d    = len_sel_s;
          cnt_d    = {CNT_W{1'b0}};
        end else begin
          state_d  = S_IDLE;
        end
      end
      S_RUN: begin
        if (cnt_q == len_last_s) begin
          state_d = S_DONE;
          cnt_d   = {CNT_W{1'b0}};
        end else begin
          cnt_d   = cnt_q + CNT_W'(1);
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        if (cur_id_q == IDX_W'(N - 1)) begin
          ptr_d = {IDX_W{1'b0}};
        end else begin
          ptr_d = cur_id_q + IDX_W'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = {CNT_W{1'b0}};
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= {CNT_W{1'b0}};
      len_q    <= {CNT_W{1'b0}};
      ptr_q    <= {IDX_W{1'b0}};
      cur_id_q <= {IDX_W{1'b0}};
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      len_q    <= len_d;
      ptr_q    <= ptr_d;
      cur_id_q <= cur_id_d;
    end
  end

  // Outputs are pure decodes of registered state.
  always_comb begin
    o_idle   = (state_q == S_IDLE);
    o_run    = (state_q == S_RUN);
    o_cur_id = cur_id_q;
    if (state_q == S_RUN) begin
      o_grant = owner_oh_s;
    end else begin
      o_grant = {N{1'b0}};
    end
    if (state_q == S_DONE) begin
      o_done = owner_oh_s;
    end else begin
      o_done = {N{1'b0}};
    end
  end

endmodule

// File: tb/tb_counter_scheduler.sv
// Directed bench for counter_scheduler: scoreboard of expected completions plus per-step timing checks.
module tb_counter_scheduler;

  localparam int N     = 4;
  localparam int CNT_W = 7;

  logic               clk = 1'b0;
  logic               reset;
  logic [N-1:0]       i_req;
  logic [N*CNT_W-1:0] i_num_cnt;
  logic [N-1:0]       o_grant;
  logic [N-1:0]       o_done;
  logic               o_idle;
  logic               o_run;
  logic [1:0]         o_cur_id;

  typedef struct {
    int id;
    int len;
  } job_t;

  job_t       sb[$];
  int         pass_cnt  = 0;
  int         fail_cnt  = 0;
  int         total_cnt = 0;
  bit         mon_en    = 1'b0;
  int         run_len   = 0;
  logic [N-1:0] last_grant = '0;

  counter_scheduler #(.N(N), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .i_req     (i_req),
    .i_num_cnt (i_num_cnt),
    .o_grant   (o_grant),
    .o_done    (o_done),
    .o_idle    (o_idle),
    .o_run     (o_run),
    .o_cur_id  (o_cur_id)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int run_cycles(input int len);
    return ((len % 128) == 0) ? 128 : len;
  endfunction

  function automatic int flen(input int j);
    return ((j * 7 + 3) % 6) + 1;
  endfunction

  task automatic set_len(input int slot, input int len);
    logic [31:0] v;
    v = len;
    i_num_cnt[slot*CNT_W +: CNT_W] = v[CNT_W-1:0];
  endtask

  task automatic push_job(input int id, input int len);
    job_t j;
    j.id  = id;
    j.len = run_cycles(len);
    sb.push_back(j);
  endtask

  task automatic wait_done(input int limit, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (o_done == 4'b0000 && n < limit);
    chk("wait_done_timeout", 32'(|o_done), 32'd1);
  endtask

  // Scoreboard monitor: grant/done invariants every cycle, job identity and length on each completion.
  always @(negedge clk) begin
    job_t j;
    if (mon_en) begin
      chk("grant_onehot0", 32'($onehot0(o_grant)), 32'd1);
      chk("grant_done_excl", 32'((|o_grant) && (|o_done)), 32'd0);
      if (|o_grant) begin
        run_len++;
        last_grant = o_grant;
      end
      if (|o_done) begin
        if (sb.size() == 0) begin
          chk("unexpected_done", 32'(o_done), 32'd0);
        end else begin
          j = sb.pop_front();
          chk("sb_done_id", 32'(o_done), 32'd1 << j.id);
          chk("sb_grant_id", 32'(last_grant), 32'd1 << j.id);
          chk("sb_run_len", 32'(run_len), 32'(j.len));
        end
        run_len = 0;
      end else if (o_idle) begin
        run_len = 0;
      end
    end
  end

  initial begin
    int n;
    reset     = 1'b1;
    i_req     = 4'b0000;
    i_num_cnt = '0;
    repeat (3) @(negedge clk);
    chk("rst_grant", 32'(o_grant), 32'd0);
    chk("rst_done", 32'(o_done), 32'd0);
    chk("rst_run", 32'(o_run), 32'd0);
    chk("rst_idle", 32'(o_idle), 32'd1);
    chk("rst_cur_id", 32'(o_cur_id), 32'd0);
    reset  = 1'b0;
    mon_en = 1'b1;

    // Single requester, len 5.
    @(negedge clk);
    i_req = 4'b0001;
    set_len(0, 5);
    push_job(0, 5);
    @(posedge clk);
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      if (k == 1) i_req = 4'b0000;
      chk("t1_grant", 32'(o_grant), 32'd1);
      chk("t1_run", 32'(o_run), 32'd1);
    end
    @(negedge clk);
    chk("t1_done", 32'(o_done), 32'd1);
    chk("t1_grant_off", 32'(o_grant), 32'd0);
    @(negedge clk);
    chk("t1_idle", 32'(o_idle), 32'd1);
    chk("t1_done_off", 32'(o_done), 32'd0);

    // Contention 1 and 3, both len 3: order 1, 3, 1 with 5-cycle spacing.
    @(negedge clk);
    i_req = 4'b1010;
    set_len(1, 3);
    set_len(3, 3);
    push_job(1, 3);
    push_job(3, 3);
    push_job(1, 3);
    wait_done(20, n);
    chk("t2_first_latency", 32'(n), 32'd4);
    wait_done(20, n);
    chk("t2_gap_a", 32'(n), 32'd5);
    wait_done(20, n);
    chk("t2_gap_b", 32'(n), 32'd5);
    i_req = 4'b0000;

    // Length edges: len 1 then len 0 (full 128-cycle run).
    @(negedge clk);
    i_req = 4'b0100;
    set_len(2, 1);
    push_job(2, 1);
    wait_done(10, n);
    chk("t3_len1_latency", 32'(n), 32'd2);
    i_req = 4'b0000;
    @(negedge clk);
    i_req = 4'b1000;
    set_len(3, 0);
    push_job(3, 0);
    wait_done(200, n);
    chk("t3_len0_latency", 32'(n), 32'd129);
    i_req = 4'b0000;

    // Late length change and request drop during RUN.
    @(negedge clk);
    i_req = 4'b0001;
    set_len(0, 4);
    push_job(0, 4);
    @(negedge clk);
    chk("t4_run", 32'(o_run), 32'd1);
    set_len(0, 9);
    i_req = 4'b0000;
    wait_done(20, n);
    chk("t4_latency", 32'(n), 32'd4);

    // Reset at RUN cycle 2 of a len-10 job: no completion may follow.
    @(negedge clk);
    i_req = 4'b0010;
    set_len(1, 10);
    @(posedge clk);
    @(negedge clk);
    i_req = 4'b0000;
    chk("t5_run_c1", 32'(o_run), 32'd1);
    @(negedge clk);
    chk("t5_grant_c2", 32'(o_grant), 32'd2);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("t5_rst_grant", 32'(o_grant), 32'd0);
    chk("t5_rst_done", 32'(o_done), 32'd0);
    chk("t5_rst_run", 32'(o_run), 32'd0);
    chk("t5_rst_idle", 32'(o_idle), 32'd1);
    chk("t5_rst_cur_id", 32'(o_cur_id), 32'd0);
    repeat (15) @(negedge clk);
    chk("t5_still_idle", 32'(o_idle), 32'd1);

    // Fairness: all four held for 40 jobs with varying lengths; pointer restarts at 0.
    for (int i = 0; i < N; i++) set_len(i, flen(i));
    for (int j = 0; j < 40; j++) push_job(j % N, flen(j));
    i_req = 4'b1111;
    for (int j = 0; j < 40; j++) begin
      wait_done(20, n);
      if (j == 39) i_req = 4'b0000;
      else set_len((j + 1) % N, flen(j + 1));
    end

    repeat (3) @(negedge clk);
    chk("sb_empty", 32'(sb.size()), 32'd0);
    chk("final_idle", 32'(o_idle), 32'd1);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
